// File: rtl/cmac_feeder_if.sv
`default_nettype none
// ============================================================================
//  Module   : cmac_feeder_if
//  Purpose  : Pair stream from the CMAC feeder to the FP16 MAC stage.
//             Carries {data, weight, last} under a valid/ready handshake.
//  Revision : 1.0 - initial release
// ============================================================================
interface cmac_feeder_if #(
   parameter int DW = 16
);
   logic [DW-1:0] out_data;
   logic [DW-1:0] out_weight;
   logic          out_last;
   logic          out_valid;
   logic          out_ready;

   // Feeder side: drives the pair, observes backpressure
   modport master (
      output out_data,
      output out_weight,
      output out_last,
      output out_valid,
      input  out_ready
   );

   // MAC side: consumes the pair, drives backpressure
   modport slave (
      input  out_data,
      input  out_weight,
      input  out_last,
      input  out_valid,
      output out_ready
   );
endinterface
`default_nettype wire

// File: rtl/cmac_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : cmac_feeder
//  Purpose  : Walks KLEN consecutive data/weight buffer addresses on start and
//             streams aligned {data, weight} pairs to the FP16 MAC, marking
//             the final pair of each kernel window. A 2-entry skid FIFO with
//             a fall-through path absorbs the 1-cycle RAM read latency and
//             downstream backpressure.
//  Options  : CMAC_FEEDER_ZERO_SKIP_EN - drop pairs with a +-0 operand
//             (except the final pair) and count them on skipped_cnt_o.
//  Revision : 1.0 - initial release
// ============================================================================
module cmac_feeder #(
   parameter int DW = 16,
   parameter int AW = 12,
   parameter int LW = 16
) (
   input  wire logic          clk,
   input  wire logic          rst,
   input  wire logic          start_i,
   input  wire logic [LW-1:0] klen_i,
   input  wire logic [AW-1:0] data_base_i,
   input  wire logic [AW-1:0] weight_base_i,
   output logic      [AW-1:0] data_addr_o,
   output logic               data_rd_o,
   input  wire logic [DW-1:0] data_rdata_i,
   output logic      [AW-1:0] weight_addr_o,
   output logic               weight_rd_o,
   input  wire logic [DW-1:0] weight_rdata_i,
   cmac_feeder_if.master      mac_o,
   output logic               busy_o,
   output logic               done_o
`ifdef CMAC_FEEDER_ZERO_SKIP_EN
   ,
   output logic      [LW-1:0] skipped_cnt_o
`endif
);

   // FIFO entry layout: {last, weight, data}
   localparam int c_EW = 2 * DW + 1;

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_FETCH = 2'd1;
   localparam logic [1:0] c_DRAIN = 2'd2;
   localparam logic [1:0] c_DONE  = 2'd3;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [1:0]      state_q, state_d;
   logic [LW-1:0]   klen_q, klen_d;
   logic [LW-1:0]   idx_q, idx_d;
   logic [AW-1:0]   daddr_q, daddr_d;
   logic [AW-1:0]   waddr_q, waddr_d;
   logic            inflight_q, inflight_d;
   logic            inflight_last_q, inflight_last_d;

   logic [1:0]      cnt_q, cnt_d;
   logic            wr_ptr_q, wr_ptr_d;
   logic            rd_ptr_q, rd_ptr_d;
   logic [c_EW-1:0] mem_q [2];

   // ------------------------------------------------------------------------
   // Combinational nets
   // ------------------------------------------------------------------------
   logic            w_start;
   logic [2:0]      w_occ;
   logic            w_rd;
   logic            w_rd_last;
   logic [c_EW-1:0] w_ret_entry;
   logic            w_drop;
   logic            w_ret_valid;
   logic            w_empty;
   logic [c_EW-1:0] w_head;
   logic            w_out_valid;
   logic            w_xfer;
   logic            w_pop;
   logic            w_push;
   logic            w_last_xfer;

   // A start is only honoured from IDLE; anything else is dropped on the floor
   assign w_start = start_i && (state_q == c_IDLE);

   // Occupancy plus the read whose data lands next cycle. Holding this under
   // two guarantees every returning word finds a free FIFO slot, so the RAM
   // side never has to stall or retry.
   assign w_occ     = {1'b0, cnt_q} + {2'b00, inflight_q};
   assign w_rd      = (state_q == c_FETCH) && (w_occ < 3'd2);
   assign w_rd_last = (idx_q == (klen_q - LW'(1)));

   assign data_addr_o   = daddr_q;
   assign weight_addr_o = waddr_q;
   assign data_rd_o     = w_rd;
   assign weight_rd_o   = w_rd;

   // Word returning from the RAMs this cycle (issued last cycle)
   assign w_ret_entry = {inflight_last_q, weight_rdata_i, data_rdata_i};

`ifdef CMAC_FEEDER_ZERO_SKIP_EN
   logic          w_zero_pair;
   logic [LW-1:0] skipped_cnt_q;

   // Sign bit ignored so both +0 and -0 count as zero; the final pair is
   // always kept so the window still terminates with out_last and done.
   assign w_zero_pair   = (data_rdata_i[DW-2:0] == '0) || (weight_rdata_i[DW-2:0] == '0);
   assign w_drop        = inflight_q && !inflight_last_q && w_zero_pair;
   assign skipped_cnt_o = skipped_cnt_q;

   // Dropped-pair counter, restarted with every accepted window
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         skipped_cnt_q <= '0;
      end else if (w_start) begin
         skipped_cnt_q <= '0;
      end else if (w_drop) begin
         skipped_cnt_q <= skipped_cnt_q + LW'(1);
      end
   end
`else
   assign w_drop = 1'b0;
`endif

   assign w_ret_valid = inflight_q && !w_drop;
   assign w_empty     = (cnt_q == 2'd0);

   // Fall-through: with the FIFO empty the returning word is presented
   // directly, which gives the 2-cycle start-to-valid latency. When nothing
   // is available the outputs are forced to zero rather than showing stale
   // RAM data.
   assign w_head      = w_empty ? (w_ret_valid ? w_ret_entry : '0) : mem_q[rd_ptr_q];
   assign w_out_valid = !w_empty || w_ret_valid;
   assign w_xfer      = w_out_valid && mac_o.out_ready;
   assign w_pop       = w_xfer && !w_empty;
   // A bypassed word consumed this cycle is never stored; a stalled bypass
   // word is captured so it stays on the outputs unchanged next cycle.
   assign w_push      = w_ret_valid && !(w_empty && mac_o.out_ready);
   assign w_last_xfer = w_xfer && w_head[c_EW-1];

   assign mac_o.out_data   = w_head[DW-1:0];
   assign mac_o.out_weight = w_head[2*DW-1:DW];
   assign mac_o.out_last   = w_head[c_EW-1];
   assign mac_o.out_valid  = w_out_valid;

   assign busy_o = (state_q == c_FETCH) || (state_q == c_DRAIN);
   assign done_o = (state_q == c_DONE);

   // Window sequencing: fetch until the last read is issued, then drain
   // until the last pair has left, then a single done cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         c_IDLE: begin
            if (w_start) begin
               state_d = (klen_i != '0) ? c_FETCH : c_DONE;
            end
         end
         c_FETCH: begin
            if (w_rd && w_rd_last) begin
               state_d = c_DRAIN;
            end
         end
         c_DRAIN: begin
            if (w_last_xfer || (w_empty && !inflight_q)) begin
               state_d = c_DONE;
            end
         end
         c_DONE: begin
            state_d = c_IDLE;
         end
         default: begin
            state_d = c_IDLE;
         end
      endcase
   end

   // Address/index walk: load the window on start, advance on each read
   always_comb begin
      klen_d          = klen_q;
      idx_d           = idx_q;
      daddr_d         = daddr_q;
      waddr_d         = waddr_q;
      inflight_d      = w_rd;
      inflight_last_d = w_rd && w_rd_last;
      if (w_start) begin
         klen_d  = klen_i;
         idx_d   = '0;
         daddr_d = data_base_i;
         waddr_d = weight_base_i;
      end else if (w_rd) begin
         idx_d   = idx_q + LW'(1);
         daddr_d = daddr_q + AW'(1);
         waddr_d = waddr_q + AW'(1);
      end
   end

   // Skip FIFO pointer and occupancy bookkeeping
   always_comb begin
      cnt_d    = cnt_q + {1'b0, w_push} - {1'b0, w_pop};
      wr_ptr_d = wr_ptr_q ^ w_push;
      rd_ptr_d = rd_ptr_q ^ w_pop;
   end

   // Control and walk registers; reset aborts the window and forgets any read
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= c_IDLE;
         klen_q          <= '0;
         idx_q           <= '0;
         daddr_q         <= '0;
         waddr_q         <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         klen_q          <= klen_d;
         idx_q           <= idx_d;
         daddr_q         <= daddr_d;
         waddr_q         <= waddr_d;
         inflight_q      <= inflight_d;
         inflight_last_q <= inflight_last_d;
      end
   end

   // Skid FIFO storage and pointers; reset flushes every entry
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q    <= 2'd0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         mem_q[0] <= '0;
         mem_q[1] <= '0;
      end else begin
         cnt_q    <= cnt_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         if (w_push) begin
            mem_q[wr_ptr_q] <= w_ret_entry;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cmac_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cmac_feeder
//  Purpose  : Self-checking bench for cmac_feeder with RAM models and a
//             scoreboard of expected {last, weight, data} pairs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cmac_feeder;
   localparam int DW = 16;
   localparam int AW = 12;
   localparam int LW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [LW-1:0] klen;
   logic [AW-1:0] data_base;
   logic [AW-1:0] weight_base;
   logic [AW-1:0] data_addr;
   logic          data_rd;
   logic [DW-1:0] data_rdata;
   logic [AW-1:0] weight_addr;
   logic          weight_rd;
   logic [DW-1:0] weight_rdata;
   logic          busy;
   logic          done;
`ifdef CMAC_FEEDER_ZERO_SKIP_EN
   logic [LW-1:0] skipped_cnt;
`endif

   cmac_feeder_if #(.DW(DW)) mac_bus ();

   cmac_feeder #(.DW(DW), .AW(AW), .LW(LW)) dut (
      .clk           (clk),
      .rst           (rst),
      .start_i       (start),
      .klen_i        (klen),
      .data_base_i   (data_base),
      .weight_base_i (weight_base),
      .data_addr_o   (data_addr),
      .data_rd_o     (data_rd),
      .data_rdata_i  (data_rdata),
      .weight_addr_o (weight_addr),
      .weight_rd_o   (weight_rd),
      .weight_rdata_i(weight_rdata),
      .mac_o         (mac_bus),
      .busy_o        (busy),
      .done_o        (done)
`ifdef CMAC_FEEDER_ZERO_SKIP_EN
      ,
      .skipped_cnt_o (skipped_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Synchronous-read RAM models
   logic [DW-1:0] dmem [0:4095];
   logic [DW-1:0] wmem [0:4095];
   always @(posedge clk) begin
      if (data_rd)   data_rdata   <= dmem[data_addr];
      if (weight_rd) weight_rdata <= wmem[weight_addr];
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   logic [2*DW:0] sb_q [$];
   logic [AW-1:0] addr_log [$];
   int cyc = 0;
   int c0;
   int first_xfer_cyc = -1;
   int done_cyc = -1;
   int rd_cnt = 0;
   int xfer_cnt = 0;
   int last_cnt = 0;
   int max_out = 0;
   int stab_err = 0;
   int rd_mismatch = 0;
   logic toggle_en = 1'b0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // out_ready driver: held high, or the 1,0,0,1 pattern when toggling
   initial begin
      logic [3:0] pat;
      int ph;
      pat = 4'b1001;
      ph  = 0;
      mac_bus.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (toggle_en) begin
            mac_bus.out_ready = pat[ph];
            ph = (ph + 1) % 4;
         end else begin
            mac_bus.out_ready = 1'b1;
            ph = 0;
         end
      end
   end

   // Monitor: scoreboard pops, outstanding bound, stall stability, address log
   initial begin
      logic          stall_pending;
      logic [2*DW:0] stall_val;
      logic [2*DW:0] obs;
      logic [2*DW:0] exp;
      int            outstanding;
      stall_pending = 1'b0;
      stall_val     = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            stall_pending = 1'b0;
         end else begin
            obs = {mac_bus.out_last, mac_bus.out_weight, mac_bus.out_data};
            outstanding = rd_cnt + int'(data_rd) - xfer_cnt;
            if (outstanding > max_out) max_out = outstanding;
            if (data_rd !== weight_rd) rd_mismatch++;
            if (data_rd) begin
               rd_cnt++;
               addr_log.push_back(data_addr);
            end
            if (stall_pending && !(mac_bus.out_valid && obs == stall_val)) stab_err++;
            stall_pending = mac_bus.out_valid && !mac_bus.out_ready;
            stall_val     = obs;
            if (mac_bus.out_valid && mac_bus.out_ready) begin
               if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
               exp = (sb_q.size() != 0) ? sb_q.pop_front() : 'x;
               check("pair", obs, exp);
               xfer_cnt++;
               if (mac_bus.out_last) last_cnt++;
            end
            if (done) done_cyc = cyc;
         end
      end
   end

   // Queue the expected pairs for a window, then pulse start for one cycle
   task automatic start_window(input int kl, input logic [AW-1:0] db, input logic [AW-1:0] wb);
      logic [AW-1:0] da;
      logic [AW-1:0] wa;
      logic          lst;
      logic          keep;
      for (int n = 0; n < kl; n++) begin
         da   = db + AW'(n);
         wa   = wb + AW'(n);
         lst  = (n == kl - 1);
         keep = 1'b1;
`ifdef CMAC_FEEDER_ZERO_SKIP_EN
         if (!lst && (dmem[da][14:0] == 15'd0 || wmem[wa][14:0] == 15'd0)) keep = 1'b0;
`endif
         if (keep) sb_q.push_back({lst, wmem[wa], dmem[da]});
      end
      first_xfer_cyc = -1;
      done_cyc       = -1;
      @(negedge clk);
      start       = 1'b1;
      klen        = LW'(kl);
      data_base   = db;
      weight_base = wb;
      c0          = cyc;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int bound);
      for (int i = 0; i < bound && done_cyc < 0; i++) begin
         @(negedge clk);
         #1;
      end
      check(tag, (done_cyc >= 0), 1);
   endtask

   initial begin
      int            x0;
      int            l0;
      logic [AW-1:0] ea [3];
      for (int a = 0; a < 4096; a++) begin
         dmem[a] = {4'h4, 12'(a)};
         wmem[a] = {4'h2, 12'(a) ^ 12'hA5A};
      end
      rst = 1'b1;
      start = 1'b0;
      klen = '0;
      data_base = '0;
      weight_base = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", mac_bus.out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_data_rd", data_rd, 0);
      check("rst_data_addr", data_addr, 0);
      rst = 1'b0;

      // 1: latency, throughput, last and done timing
      start_window(4, 12'h010, 12'h200);
      wait_done("t1_done_seen", 50);
      check("t1_first_valid_cycle", first_xfer_cyc - c0, 2);
      check("t1_done_cycle", done_cyc - c0, 6);
      check("t1_last_count", last_cnt, 1);
      check("t1_sb_empty", sb_q.size(), 0);
      @(negedge clk);
      check("t1_done_one_cycle", done, 0);
      check("t1_busy_low", busy, 0);

      // 2: backpressure pattern
      rd_cnt = 0; xfer_cnt = 0; max_out = 0; stab_err = 0;
      toggle_en = 1'b1;
      start_window(8, 12'h100, 12'h300);
      wait_done("t2_done_seen", 300);
      toggle_en = 1'b0;
      check("t2_pairs", xfer_cnt, 8);
      check("t2_max_outstanding_ok", (max_out <= 2), 1);
      check("t2_stall_stable_errs", stab_err, 0);
      check("t2_sb_empty", sb_q.size(), 0);

      // 3: address wrap
      repeat (2) @(negedge clk);
      addr_log.delete();
      start_window(3, 12'hFFE, 12'h100);
      wait_done("t3_done_seen", 50);
      ea = '{12'hFFE, 12'hFFF, 12'h000};
      check("t3_reads", addr_log.size(), 3);
      for (int i = 0; i < 3 && i < addr_log.size(); i++) check("t3_addr", addr_log[i], ea[i]);
      check("t3_sb_empty", sb_q.size(), 0);

      // 4: zero-length window, then start while busy
      repeat (2) @(negedge clk);
      x0 = xfer_cnt;
      start_window(0, 12'h000, 12'h000);
      wait_done("t4_done_seen", 20);
      check("t4_done_cycle", done_cyc - c0, 1);
      check("t4_no_pairs", xfer_cnt - x0, 0);
      repeat (2) @(negedge clk);
      x0 = xfer_cnt;
      l0 = last_cnt;
      start_window(4, 12'h400, 12'h500);
      start = 1'b1; klen = 16'd8; data_base = 12'h800; weight_base = 12'h900;
      @(negedge clk);
      start = 1'b0;
      check("t4_busy_during", busy, 1);
      wait_done("t4b_done_seen", 50);
      check("t4_pairs", xfer_cnt - x0, 4);
      check("t4_last", last_cnt - l0, 1);
      check("t4_sb_empty", sb_q.size(), 0);
      repeat (4) @(negedge clk);
      check("t4_not_restarted", busy, 0);

      // 5: reset in mid-window
      x0 = xfer_cnt;
      start_window(8, 12'h020, 12'h600);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         #2;
         if (xfer_cnt - x0 >= 3) break;
      end
      check("t5_three_sent", (xfer_cnt - x0 >= 3), 1);
      rst = 1'b1;
      #1;
      check("t5_rst_out_valid", mac_bus.out_valid, 0);
      check("t5_rst_busy", busy, 0);
      check("t5_rst_data_rd", data_rd, 0);
      check("t5_rst_data_addr", data_addr, 0);
      check("t5_rst_out_data", mac_bus.out_data, 0);
      sb_q.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      rd_cnt = 0; xfer_cnt = 0;
      start_window(4, 12'h030, 12'h700);
      wait_done("t5_done_seen", 50);
      check("t5_pairs_after_reset", xfer_cnt, 4);
      check("t5_sb_empty", sb_q.size(), 0);

`ifdef CMAC_FEEDER_ZERO_SKIP_EN
      // 6: zero skipping
      repeat (2) @(negedge clk);
      dmem[12'h040] = 16'h3C00;
      dmem[12'h041] = 16'h0000;
      dmem[12'h042] = 16'h8000;
      dmem[12'h043] = 16'h0000;
      x0 = xfer_cnt;
      l0 = last_cnt;
      start_window(4, 12'h040, 12'h240);
      wait_done("t6_done_seen", 50);
      check("t6_pairs", xfer_cnt - x0, 2);
      check("t6_last", last_cnt - l0, 1);
      check("t6_skipped_cnt", skipped_cnt, 2);
      check("t6_sb_empty", sb_q.size(), 0);
`endif

      check("rd_enables_equal_errs", rd_mismatch, 0);
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
`default_nettype wire
